// File: rtl/abs_share_arbiter.sv
// Round-robin arbiter that shares one external combinational abs/negate datapath
// between NREQ requesters, with a single registered result stage.
module abs_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [WIDTH-1:0]      dp_in,
  input  logic [WIDTH-1:0]      dp_abs,
  input  logic [WIDTH-1:0]      dp_neg,
  input  logic                  dp_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_sign,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id,
  output logic                  dbg_state,
  output logic [IDW-1:0]        dbg_rr_ptr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready may depend on valid.

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] next_ptr;
  logic [IDW:0]   cand;
  logic           grant_found;
  logic           can_accept;
  logic           accept;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign can_accept = (state == IDLE) || ((state == FULL) && rsp_ready);
  assign accept     = grant_found && can_accept && !reset;
  assign next_ptr   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  assign dp_in      = accept ? req_data[grant_idx*WIDTH +: WIDTH] : '0;
  assign dbg_state  = (state == FULL);
  assign dbg_rr_ptr = rr_ptr;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // A consume and a new accept on the same edge overwrite the result register
  // directly, so back-to-back results never see a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sign  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= '0;
    end else if (accept) begin
      state     <= FULL;
      rsp_valid <= 1'b1;
      rsp_data  <= req_op[grant_idx] ? dp_neg : dp_abs;
      rsp_sign  <= dp_sign;
      rsp_ovf   <= (dp_in == MOST_NEG);
      rsp_id    <= grant_idx;
      rr_ptr    <= next_ptr;
    end else if ((state == FULL) && rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abs_share_arbiter.sv
// Directed bench for abs_share_arbiter: driver issues vectors and queues the
// hand-computed results, a negedge monitor pops and compares on each handshake.
module tb_abs_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
  localparam int W     = IDW + 2 + WIDTH;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [WIDTH-1:0]      dp_in;
  logic [WIDTH-1:0]      dp_abs;
  logic [WIDTH-1:0]      dp_neg;
  logic                  dp_sign;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_sign;
  logic                  rsp_ovf;
  logic [IDW-1:0]        rsp_id;
  logic                  dbg_state;
  logic [IDW-1:0]        dbg_rr_ptr;

  logic [W-1:0] exp_q[$];
  int           check_cnt = 0;
  int           pass_cnt  = 0;

  logic [WIDTH-1:0] t3_res[NREQ];
  logic             t3_sign[NREQ];

  abs_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .dp_in(dp_in), .dp_abs(dp_abs), .dp_neg(dp_neg), .dp_sign(dp_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sign(rsp_sign), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // External abs/negate datapath (wraps on the most-negative value).
  assign dp_neg  = -dp_in;
  assign dp_abs  = dp_in[WIDTH-1] ? -dp_in : dp_in;
  assign dp_sign = dp_in[WIDTH-1];

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver tasks (called at posedge+1)
  task automatic set_req(input int i, input logic op, input logic [WIDTH-1:0] data);
    req_op[i]                = op;
    req_data[i*WIDTH +: WIDTH] = data;
    req_valid[i]             = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input string name, input logic [NREQ-1:0] exp_grant,
                      input bit push, input logic [W-1:0] exp_rsp);
    @(negedge clk);
    check(name, 64'(req_ready), 64'(exp_grant));
    if (push) exp_q.push_back(exp_rsp);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL rsp_unexpected: got %h expected no response",
                 {rsp_id, rsp_ovf, rsp_sign, rsp_data});
      end else begin
        check("rsp", 64'({rsp_id, rsp_ovf, rsp_sign, rsp_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    t3_res[0] = 32'h0000_0010; t3_sign[0] = 1'b0;
    t3_res[1] = 32'h0000_0001; t3_sign[1] = 1'b1;
    t3_res[2] = 32'h7FFF_FFFF; t3_sign[2] = 1'b0;
    t3_res[3] = 32'h0000_0100; t3_sign[3] = 1'b1;

    // 1: reset with every requester valid
    reset     = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_rsp_id", 64'(rsp_id), 64'(0));
    end
    check("reset_rsp_data", 64'({rsp_ovf, rsp_sign, rsp_data}), 64'(0));
    check("reset_state", 64'({dbg_state, dbg_rr_ptr}), 64'(0));
    @(posedge clk);
    #1;

    // 2: single abs of -5
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'hFFFF_FFFB);
    step("t2_grant", 4'b0001, 1'b1, {2'd0, 1'b0, 1'b1, 32'h0000_0005});
    req_valid = '0;
    idle(1);
    // abs(0) from req3 also brings rr_ptr back to 0
    set_req(3, 1'b0, 32'h0000_0000);
    step("abs0_grant", 4'b1000, 1'b1, {2'd3, 1'b0, 1'b0, 32'h0000_0000});
    req_valid = '0;
    idle(1);

    // 3: all four valid continuously
    set_req(0, 1'b0, 32'h0000_0010);
    set_req(1, 1'b0, 32'hFFFF_FFFF);
    set_req(2, 1'b0, 32'h7FFF_FFFF);
    set_req(3, 1'b1, 32'hFFFF_FF00);
    for (int c = 0; c < 6; c++) begin
      int g;
      g = c % NREQ;
      step("rr_grant", 4'b0001 << g, 1'b1, {IDW'(g), 1'b0, t3_sign[g], t3_res[g]});
    end
    req_valid = '0;
    idle(2);

    // 4: backpressure holds the result, then consume and accept together
    rsp_ready = 1'b0;
    set_req(2, 1'b0, 32'hFFFF_FFF0);
    step("t4_grant", 4'b0100, 1'b1, {2'd2, 1'b0, 1'b1, 32'h0000_0010});
    req_valid = '0;
    set_req(0, 1'b1, 32'h0000_0003);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp", 64'({rsp_id, rsp_ovf, rsp_sign, rsp_data}),
            64'({2'd2, 1'b0, 1'b1, 32'h0000_0010}));
      check("hold_req_ready", 64'(req_ready), 64'(0));
      check("hold_dp_in", 64'(dp_in), 64'(0));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    step("t4_same_cycle", 4'b0001, 1'b1, {2'd0, 1'b0, 1'b0, 32'hFFFF_FFFD});
    req_valid = '0;
    @(negedge clk);
    check("no_bubble", 64'(rsp_valid), 64'(1));
    @(posedge clk);
    #1;
    idle(1);

    // 5: overflow cases, rr_ptr now 1
    set_req(1, 1'b1, 32'h0000_0007);
    set_req(2, 1'b1, 32'h8000_0000);
    set_req(3, 1'b0, 32'h8000_0000);
    step("t5_grant1", 4'b0010, 1'b1, {2'd1, 1'b0, 1'b0, 32'hFFFF_FFF9});
    req_valid[1] = 1'b0;
    step("t5_grant2", 4'b0100, 1'b1, {2'd2, 1'b1, 1'b1, 32'h8000_0000});
    req_valid[2] = 1'b0;
    step("t5_grant3", 4'b1000, 1'b1, {2'd3, 1'b1, 1'b1, 32'h8000_0000});
    req_valid = '0;
    idle(2);

    // 6: reset while FULL drops the pending result
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 32'h0000_0009);
    step("t6_fill", 4'b0010, 1'b0, '0);
    req_valid = 4'b1110;
    reset     = 1'b1;
    @(negedge clk);
    check("t6_reset_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
    check("t6_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    step("t6_first_grant", 4'b0010, 1'b1, {2'd1, 1'b0, 1'b0, 32'h0000_0009});
    req_valid = '0;
    idle(3);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
